add_tree_checker: RTL and testbench

- Driving and receiving end of the registered adder-tree datapath.
- Generates pseudo-random operand vectors on a, b, c and d, and captures the tree's sum after a fixed pipeline latency.
- Compares each captured sum against an internally delayed expected value, counts mismatches and reports pass/fail.
- Sits beside the tree in self-test and regression harnesses as the operand source and result sink.

---
 rtl/add_tree_checker_pkg.sv | 23 ++
 rtl/add_tree_checker_dly.sv | 48 ++++
 rtl/add_tree_checker.sv | 149 ++++++++++++++
 tb/tb_add_tree_checker.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/add_tree_checker_pkg.sv
// Shared definitions for the adder-tree checker.
//   state_t    : checker FSM states
//   LFSR_W     : operand generator width
//   LFSR_MASK  : Galois feedback taps
//   lfsr_next(): one right-shift step of the Galois LFSR
package add_tree_checker_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int                LFSR_W    = 32;
   localparam logic [LFSR_W-1:0] LFSR_MASK = 32'h80200003;

   // Shift right; the bit falling out of the LSB decides whether the taps are applied.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_MASK : '0);
   endfunction

endpackage

// File: rtl/add_tree_checker_dly.sv
// LATENCY-deep delay line for the expected tree result.
// Ports:
//   clk, rst_n           : clock, async active-low clear of every stage
//   in_valid/idx/exp     : entry pushed at each clock edge
//   out_valid/idx/exp    : entry pushed LATENCY edges earlier
module add_tree_checker_dly #(
   parameter int W       = 4,
   parameter int CNT_W   = 8,
   parameter int LATENCY = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [CNT_W-1:0] in_idx,
   input  logic [W-1:0]     in_exp,
   output logic             out_valid,
   output logic [CNT_W-1:0] out_idx,
   output logic [W-1:0]     out_exp
);

   logic             vld_q [LATENCY];
   logic [CNT_W-1:0] idx_q [LATENCY];
   logic [W-1:0]     exp_q [LATENCY];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < LATENCY; s++) begin
            vld_q[s] <= 1'b0;
            idx_q[s] <= '0;
            exp_q[s] <= '0;
         end
      end else begin
         for (int s = LATENCY - 1; s > 0; s--) begin
            vld_q[s] <= vld_q[s-1];
            idx_q[s] <= idx_q[s-1];
            exp_q[s] <= exp_q[s-1];
         end
         vld_q[0] <= in_valid;
         idx_q[0] <= in_idx;
         exp_q[0] <= in_exp;
      end
   end

   assign out_valid = vld_q[LATENCY-1];
   assign out_idx   = idx_q[LATENCY-1];
   assign out_exp   = exp_q[LATENCY-1];

endmodule

// File: rtl/add_tree_checker.sv
// Operand source and result sink for the registered adder tree.
// Drives LFSR-derived operands on a..d for num_vec cycles, compares sum_in
// LATENCY cycles later against the locally computed sum, and reports the
// mismatch count, first failing vector index and a pass flag.
// Handshake: start is a single-cycle request, taken only while the FSM is
// in IDLE; any other cycle it is dropped, nothing is queued.
// Ports:
//   clk, rst_n              : clock, async active-low reset
//   start, num_vec, seed    : run request and its parameters (sampled on start)
//   a, b, c, d              : operands to the tree (0 outside DRIVE)
//   sum_in                  : tree result
//   busy, done, pass        : run status
//   err_count, first_err_idx: mismatch statistics
//   state_dbg               : current FSM state
module add_tree_checker
   import add_tree_checker_pkg::*;
#(
   parameter int W       = 4,
   parameter int LATENCY = 3,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_vec,
   input  logic [31:0]      seed,
   output logic [W-1:0]     a,
   output logic [W-1:0]     b,
   output logic [W-1:0]     c,
   output logic [W-1:0]     d,
   input  logic [W-1:0]     sum_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] first_err_idx,
   output state_t           state_dbg
);

   localparam int DW = (LATENCY < 2) ? 1 : $clog2(LATENCY);

   state_t            state_q, state_d;
   logic [LFSR_W-1:0] lfsr_q;
   logic [CNT_W-1:0]  num_q;
   logic [CNT_W-1:0]  vec_idx_q;
   logic [DW-1:0]     drain_q;
   logic [CNT_W-1:0]  err_q;
   logic [CNT_W-1:0]  first_q;
   logic              pass_q;

   logic              accept;
   logic              driving;
   logic              vec_last;
   logic              drain_last;
   logic [W-1:0]      exp_sum;
   logic              cmp_valid;
   logic [CNT_W-1:0]  cmp_idx;
   logic [W-1:0]      cmp_exp;

   assign accept     = (state_q == IDLE) && start;
   assign driving    = (state_q == DRIVE);
   assign vec_last   = (vec_idx_q == num_q - CNT_W'(1));
   assign drain_last = (drain_q == DW'(LATENCY - 1));

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = (num_vec == '0) ? DONE : DRIVE;
         DRIVE:   if (vec_last) state_d = DRAIN;
         DRAIN:   if (drain_last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Run bookkeeping and result accumulation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q    <= LFSR_W'(1);
         num_q     <= '0;
         vec_idx_q <= '0;
         drain_q   <= '0;
         err_q     <= '0;
         first_q   <= '0;
         pass_q    <= 1'b0;
      end else begin
         if (accept) begin
            lfsr_q    <= (seed == '0) ? LFSR_W'(1) : seed;
            num_q     <= num_vec;
            vec_idx_q <= '0;
            drain_q   <= '0;
            err_q     <= '0;
            first_q   <= '0;
            pass_q    <= 1'b0;
         end
         if (driving) begin
            lfsr_q    <= lfsr_next(lfsr_q);
            vec_idx_q <= vec_idx_q + CNT_W'(1);
         end
         if (state_q == DRAIN) drain_q <= drain_q + DW'(1);
         // The last comparison lands on the final DRAIN edge, so err_q is settled here.
         if (state_q == DONE) pass_q <= (err_q == '0);
         // The delay line is empty in IDLE, so this never collides with the clear above.
         if (cmp_valid && (sum_in != cmp_exp)) begin
            err_q <= err_q + CNT_W'(1);
            if (err_q == '0) first_q <= cmp_idx;
         end
      end
   end

   assign a = driving ? lfsr_q[W-1:0]     : '0;
   assign b = driving ? lfsr_q[2*W-1:W]   : '0;
   assign c = driving ? lfsr_q[3*W-1:2*W] : '0;
   assign d = driving ? lfsr_q[4*W-1:3*W] : '0;

   // Truncation to W bits gives the mod 2^W sum the tree produces.
   assign exp_sum = a + b + c + d;

   add_tree_checker_dly #(
      .W       (W),
      .CNT_W   (CNT_W),
      .LATENCY (LATENCY)
   ) u_dly (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (driving),
      .in_idx    (vec_idx_q),
      .in_exp    (exp_sum),
      .out_valid (cmp_valid),
      .out_idx   (cmp_idx),
      .out_exp   (cmp_exp)
   );

   assign busy          = (state_q == DRIVE) || (state_q == DRAIN);
   assign done          = (state_q == DONE);
   // pass reflects the final count during DONE, then the registered copy holds it.
   assign pass          = (state_q == DONE) ? (err_q == '0) : pass_q;
   assign err_count     = err_q;
   assign first_err_idx = first_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_add_tree_checker.sv
module tb_add_tree_checker;
  import add_tree_checker_pkg::*;

  localparam int W     = 4;
  localparam int LAT   = 3;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_vec = '0;
  logic [31:0]      seed = '0;
  logic [W-1:0]     a, b, c, d;
  logic [W-1:0]     sum_in;
  logic             busy, done, pass;
  logic [CNT_W-1:0] err_count, first_err_idx;
  state_t           state_dbg;

  int checks = 0;
  int errors = 0;

  add_tree_checker #(.W(W), .LATENCY(LAT), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .num_vec       (num_vec),
    .seed          (seed),
    .a             (a),
    .b             (b),
    .c             (c),
    .d             (d),
    .sum_in        (sum_in),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_idx (first_err_idx),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- ideal 3-stage registered tree with fault hook ----------------
  int   st_edge   = -100;
  bit   fault_on  = 1'b0;
  int   fault_vec = 0;
  logic [W-1:0] p0 = '0, p1 = '0, p2 = '0;

  always @(posedge clk) begin
    logic [W-1:0] s;
    s = W'((int'(a) + int'(b) + int'(c) + int'(d)) % (1 << W));
    if (fault_on && (cyc == st_edge + fault_vec)) s = s ^ W'(1);
    p0 <= s;
    p1 <= p0;
    p2 <= p1;
  end
  assign sum_in = p2;

  // ---------------- reference helpers ----------------
  function automatic logic [31:0] ref_step(input logic [31:0] s);
    if (s % 2 == 1) return (s >> 1) ^ 32'h80200003;
    return s >> 1;
  endfunction

  function automatic logic [W-1:0] ref_op(input logic [31:0] s, input int k);
    return W'((s >> (W * k)) % (1 << W));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  logic [4*W-1:0] rec_q[$];

  // One complete run; the caller sits at posedge+#1 of an IDLE cycle.
  task automatic run(input logic [31:0] sd, input int n, input int restart_at,
                     input int abort_at, input bit record);
    logic [31:0] s;
    int last;
    int exp_err;
    int exp_first;
    s         = (sd == 0) ? 32'd1 : sd;
    last      = (n == 0) ? 0 : n + LAT;
    exp_err   = (fault_on && fault_vec < n) ? 1 : 0;
    exp_first = (exp_err != 0) ? fault_vec : 0;
    num_vec   = CNT_W'(n);
    seed      = sd;
    start     = 1'b1;
    st_edge   = cyc + 1;
    @(posedge clk); #1;
    start   = 1'b0;
    num_vec = CNT_W'($urandom_range(0, 255));
    seed    = $urandom;
    for (int j = 0; j <= last + 1; j++) begin
      if (j == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_a", a, 0);
        chk("abort_b", b, 0);
        chk("abort_c", c, 0);
        chk("abort_d", d, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_pass", pass, 0);
        chk("abort_err", err_count, 0);
        chk("abort_first", first_err_idx, 0);
        @(posedge clk); #1;
        chk("abort_done_hold", done, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_abort_done", done, 0);
        chk("post_abort_busy", busy, 0);
        return;
      end
      chk("a", a, (j < n) ? ref_op(s, 0) : 0);
      chk("b", b, (j < n) ? ref_op(s, 1) : 0);
      chk("c", c, (j < n) ? ref_op(s, 2) : 0);
      chk("d", d, (j < n) ? ref_op(s, 3) : 0);
      chk("busy", busy, (n != 0 && j < n + LAT) ? 1 : 0);
      chk("done", done, (j == last) ? 1 : 0);
      if (j == last) begin
        chk("pass", pass, (exp_err == 0) ? 1 : 0);
        chk("err_count", err_count, exp_err);
        chk("first_err_idx", first_err_idx, exp_first);
      end
      if (j == last + 1) begin
        chk("pass_hold", pass, (exp_err == 0) ? 1 : 0);
        chk("err_hold", err_count, exp_err);
      end
      if (record && j < n) rec_q.push_back({a, b, c, d});
      if (j == restart_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (j < n) s = ref_step(s);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [4*W-1:0] seq0[$];
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_c", c, 0);
    chk("rst_d", d, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_first", first_err_idx, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // clean run, 16 vectors
    run(32'd1, 16, -1, -1, 1'b0);

    // single corrupted sum on vector 5
    fault_on = 1'b1; fault_vec = 5;
    run(32'd1, 16, -1, -1, 1'b0);
    fault_on = 1'b0;

    // empty run, with a start pulse landing on the DONE cycle
    run($urandom, 0, 0, -1, 1'b0);

    // start re-pulsed during DRIVE at vector 3
    run($urandom, 10, 3, -1, 1'b0);

    // reset during vector 7, then a fresh short run
    run($urandom, 10, -1, 7, 1'b0);
    run($urandom, 4, -1, -1, 1'b0);

    // seed 0 and seed 1 must produce the same operand stream
    rec_q.delete();
    run(32'd0, 8, -1, -1, 1'b1);
    seq0 = rec_q;
    rec_q.delete();
    run(32'd1, 8, -1, -1, 1'b1);
    chk("seed_len", rec_q.size(), seq0.size());
    for (int i = 0; i < 8 && i < rec_q.size() && i < seq0.size(); i++)
      chk("seed_seq", rec_q[i], seq0[i]);

    // randomized runs, some with a single injected fault
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 20);
      fault_on  = ($urandom_range(0, 1) == 1);
      fault_vec = $urandom_range(0, n - 1);
      run($urandom, n, -1, -1, 1'b0);
      fault_on = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
